// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared widths, FSM state encoding and request record for the
//          cache data-array controller.
// Rev    : 1.0
// ============================================================================
package dcache_pkg;

   localparam int INDEX_W = 6;
   localparam int LINE_W  = 128;
   localparam int STRB_W  = LINE_W / 8;
   localparam int DEPTH   = 2 ** INDEX_W;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   typedef struct packed {
      logic               write;
      logic [INDEX_W-1:0] index;
      logic [STRB_W-1:0]  wstrb;
      logic [LINE_W-1:0]  wdata;
   } da_req_t;

endpackage
`default_nettype wire

// File: rtl/data_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : data_array_ctrl
// Brief  : Sole driver of the 64x128 data-array SRAM macro pins: zero-fill
//          sweep after reset, then one line access at a time via valid/ready.
// Rev    : 1.0
// ============================================================================
module data_array_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_W = dcache_pkg::INDEX_W,
   parameter int LINE_W  = dcache_pkg::LINE_W,
   parameter int STRB_W  = LINE_W / 8,
   parameter bit INIT_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [STRB_W-1:0]  req_wstrb,
   input  logic [LINE_W-1:0]  req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_write,
   output logic [LINE_W-1:0]  rsp_rdata,
   output logic               init_done,
   output logic               sram_cs,
   output logic               sram_oe,
   output logic [STRB_W-1:0]  sram_web,
   output logic [INDEX_W-1:0] sram_a,
   output logic [LINE_W-1:0]  sram_di,
   input  logic [LINE_W-1:0]  sram_do
);

   localparam state_e           RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;
   localparam logic [INDEX_W:0] INIT_LAST = {1'b0, {INDEX_W{1'b1}}};
   localparam logic [INDEX_W:0] CNT_ONE   = {{INDEX_W{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [INDEX_W:0]   init_cnt_q, init_cnt_d;
   logic               write_q, write_d;
   da_req_t            req_in;

   logic               sram_cs_q, sram_cs_d;
   logic               sram_oe_q, sram_oe_d;
   logic [STRB_W-1:0]  sram_web_q, sram_web_d;
   logic [INDEX_W-1:0] sram_a_q, sram_a_d;
   logic [LINE_W-1:0]  sram_di_q, sram_di_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_write_q, rsp_write_d;
   logic [LINE_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic               req_ready_q, req_ready_d;
   logic               init_done_q, init_done_d;

   logic               req_fire;
   logic               rsp_fire;

   assign req_in   = '{write: req_write, index: req_index, wstrb: req_wstrb, wdata: req_wdata};
   assign req_fire = (state_q == ST_IDLE) && req_valid && req_ready_q;
   assign rsp_fire = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         init_cnt_q <= '0;
         write_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         write_q    <= write_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      write_d    = write_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + CNT_ONE;
            if (init_cnt_q == INIT_LAST) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (req_fire) begin
               write_d = req_in.write;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS:  state_d = write_q ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_fire) begin
               state_d = ST_IDLE;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   // Pin values are computed one cycle ahead so the macro sees them registered
   // for the whole cycle in which the FSM occupies the matching state.
   always_comb begin
      sram_cs_d   = 1'b0;
      sram_oe_d   = 1'b0;
      sram_web_d  = '1;
      sram_a_d    = sram_a_q;
      sram_di_d   = sram_di_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_INIT: begin
            sram_cs_d  = 1'b1;
            sram_web_d = '0;
            sram_a_d   = init_cnt_q[INDEX_W-1:0];
            sram_di_d  = '0;
         end
         ST_IDLE: begin
            if (req_fire) begin
               sram_cs_d = 1'b1;
               sram_a_d  = req_in.index;
               if (req_in.write) begin
                  sram_web_d = ~req_in.wstrb;
                  sram_di_d  = req_in.wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (write_q) begin
               rsp_write_d = 1'b1;
            end else begin
               sram_oe_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            rsp_rdata_d = sram_do;
            rsp_write_d = 1'b0;
         end
         default: ;
      endcase
      rsp_valid_d = (state_d == ST_RESP);
      req_ready_d = (state_d == ST_IDLE);
      init_done_d = init_done_q || (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_cs_q   <= 1'b0;
         sram_oe_q   <= 1'b0;
         sram_web_q  <= '1;
         sram_a_q    <= '0;
         sram_di_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         sram_cs_q   <= sram_cs_d;
         sram_oe_q   <= sram_oe_d;
         sram_web_q  <= sram_web_d;
         sram_a_q    <= sram_a_d;
         sram_di_q   <= sram_di_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         req_ready_q <= req_ready_d;
         init_done_q <= init_done_d;
      end
   end

   assign sram_cs   = sram_cs_q;
   assign sram_oe   = sram_oe_q;
   assign sram_web  = sram_web_q;
   assign sram_a    = sram_a_q;
   assign sram_di   = sram_di_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign req_ready = req_ready_q;
   assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_data_array_ctrl
// Brief  : Directed bench for data_array_ctrl with a byte-write SRAM model.
// Rev    : 1.0
// ============================================================================
module tb_data_array_ctrl;

   localparam logic [127:0] D1    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D1AA  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32AA;
   localparam logic [127:0] W2    = 128'h5555_5555_5555_5555_5555_5555_5555_55AA;
   localparam logic [127:0] ONES  = {128{1'b1}};
   localparam logic [127:0] ELVN  = {16{8'h11}};
   localparam logic [127:0] MIX10 = 128'h1111_1111_0000_0000_1111_1111_0000_0000;
   localparam logic [127:0] JUNK  = {8{16'hDEAD}};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [5:0]   req_index = '0;
   logic [15:0]  req_wstrb = '0;
   logic [127:0] req_wdata = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic         rsp_write;
   logic [127:0] rsp_rdata;
   logic         init_done;
   logic         sram_cs;
   logic         sram_oe;
   logic [15:0]  sram_web;
   logic [5:0]   sram_a;
   logic [127:0] sram_di;
   logic [127:0] sram_do;

   logic         seed = 1'b0;
   logic [127:0] mem [64];
   logic [127:0] dout_q = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_array_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_index (req_index),
      .req_wstrb (req_wstrb),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done),
      .sram_cs   (sram_cs),
      .sram_oe   (sram_oe),
      .sram_web  (sram_web),
      .sram_a    (sram_a),
      .sram_di   (sram_di),
      .sram_do   (sram_do)
   );

   // Macro model: samples pins on the rising edge, read data valid after it.
   always @(posedge clk) begin
      if (seed) begin
         for (int i = 0; i < 64; i++) mem[i] <= JUNK;
      end else if (sram_cs) begin
         if (&sram_web) begin
            dout_q <= mem[sram_a];
         end else begin
            for (int b = 0; b < 16; b++)
               if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
         end
      end
   end
   assign sram_do = sram_oe ? dout_q : '0;

   typedef struct {
      logic         write;
      logic [5:0]   idx;
      logic [15:0]  strb;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"},
          128'({sram_cs, sram_oe, sram_web, sram_a, rsp_valid, rsp_write, req_ready, init_done}),
          128'({1'b0, 1'b0, 16'hFFFF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
      chk({tag, "_di"}, sram_di, '0);
      chk({tag, "_rdata"}, rsp_rdata, '0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 128'(req_ready), 128'(1));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      wait_ready(tag);
      req_valid = 1'b1;
      req_write = v.write;
      req_index = v.idx;
      req_wstrb = v.strb;
      req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      req_index = 6'h3F;
      req_wstrb = 16'hFFFF;
      req_wdata = ONES;
      chk({tag, "_access"}, 128'({sram_cs, sram_a, sram_web}),
          128'({1'b1, v.idx, v.write ? ~v.strb : 16'hFFFF}));
      if (v.write) chk({tag, "_di"}, sram_di, v.wdata);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 128'(lat), v.write ? 128'(2) : 128'(3));
      chk({tag, "_rspwrite"}, 128'(rsp_write), 128'(v.write));
      chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
      @(negedge clk);
      chk({tag, "_rsp_done"}, 128'(rsp_valid), 128'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [127:0] held;
      logic stale;

      vecs[0] = '{1'b0, 6'd63, 16'h0000, '0,   '0};
      vecs[1] = '{1'b1, 6'd5,  16'hFFFF, D1,   '0};
      vecs[2] = '{1'b0, 6'd5,  16'h0000, '0,   D1};
      vecs[3] = '{1'b1, 6'd5,  16'h0001, W2,   D1};
      vecs[4] = '{1'b0, 6'd5,  16'h0000, '0,   D1AA};
      vecs[5] = '{1'b1, 6'd7,  16'h0000, ONES, D1AA};
      vecs[6] = '{1'b0, 6'd7,  16'h0000, '0,   '0};
      vecs[7] = '{1'b1, 6'd10, 16'hF0F0, ELVN, '0};
      vecs[8] = '{1'b0, 6'd10, 16'h0000, '0,   MIX10};

      // Reset with garbage preloaded into the array
      seed = 1'b1;
      repeat (3) @(negedge clk);
      seed = 1'b0;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-fill sweep
      n = 0;
      while (!sram_cs && n < 5) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 64; i++) begin
         chk("init_pins", 128'({sram_cs, sram_web, sram_a}), 128'({1'b1, 16'h0000, 6'(i)}));
         chk("init_di", sram_di, '0);
         if (i < 63) chk("init_busy", 128'({init_done, req_ready}), 128'(0));
         @(negedge clk);
      end
      chk("init_end", 128'({sram_cs, init_done, req_ready}), 128'({1'b0, 1'b1, 1'b1}));

      for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Backpressure on a read
      wait_ready("bp");
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_index = 6'd5;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_capture_oe", 128'({sram_oe, sram_cs}), 128'({1'b1, 1'b0}));
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      held = rsp_rdata;
      chk("bp_rdata", held, D1AA);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_stall", 128'({rsp_valid, req_ready, sram_cs, sram_oe, rsp_write}),
             128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
         chk("bp_hold", rsp_rdata, held);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 128'({rsp_valid, req_ready}), 128'({1'b0, 1'b1}));

      // Reset asserted in the middle of a read
      wait_ready("mr");
      req_valid = 1'b1;
      req_write = 1'b0;
      req_index = 6'd10;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mr_capture_oe", 128'(sram_oe), 128'(1));
      #1 rst_n = 1'b0;
      #1 chk_reset("mr_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      n = 0;
      while (!sram_cs && n < 5) begin
         stale = stale | rsp_valid;
         @(negedge clk);
         n++;
      end
      chk("mr_restart", 128'({sram_cs, sram_web, sram_a}), 128'({1'b1, 16'h0000, 6'd0}));
      n = 0;
      while (!init_done && n < 80) begin
         stale = stale | rsp_valid;
         @(negedge clk);
         n++;
      end
      chk("mr_init_done", 128'(init_done), 128'(1));
      chk("mr_no_stale_rsp", 128'(stale), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
